// File: rtl/fpu_div_sqrt_iter.sv
// Iterative mantissa divide / square-root engine for FDIV/FSQRT.
// It uses a restoring recurrence that produces a 26-bit raw result and a sticky bit, with valid/ready on both sides.
module fpu_div_sqrt_iter #(
    parameter int META_W         = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_divide,
    input  logic [23:0]       lhs_mant,
    input  logic [23:0]       rhs_mant,
    input  logic              sqrt_odd_expo,
    input  logic              special,
    input  logic [META_W-1:0] meta_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [25:0]       quo,
    output logic              sticky,
    output logic [META_W-1:0] meta_out,
    output logic              busy
);
    localparam int N = 26 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        div_op;
    logic [23:0] divisor;
    logic [29:0] rem;
    logic [51:0] rad;

    logic [29:0] rem_nx;
    logic [29:0] trial;
    logic [29:0] tmp;
    logic [25:0] quo_nx;
    logic [51:0] rad_nx;

    assign in_ready = (state == IDLE) && !flush && !rst;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch);
        // blocking '=' here lets each unrolled step see the previous step's result.
        rem_nx = rem;
        quo_nx = quo;
        rad_nx = rad;
        trial  = '0;
        tmp    = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (div_op) begin
                // The remainder stays below 2*divisor, so one compare decides each quotient bit.
                if (rem_nx >= {6'b0, divisor}) begin
                    rem_nx = (rem_nx - {6'b0, divisor}) << 1;
                    quo_nx = {quo_nx[24:0], 1'b1};
                end else begin
                    rem_nx = rem_nx << 1;
                    quo_nx = {quo_nx[24:0], 1'b0};
                end
            end else begin
                // Bring in the next radicand bit pair and trial-subtract 4*root+1.
                trial  = {2'b0, quo_nx, 2'b01};
                tmp    = {rem_nx[27:0], rad_nx[51:50]};
                rad_nx = rad_nx << 2;
                if (tmp >= trial) begin
                    rem_nx = tmp - trial;
                    quo_nx = {quo_nx[24:0], 1'b1};
                end else begin
                    rem_nx = tmp;
                    quo_nx = {quo_nx[24:0], 1'b0};
                end
            end
        end
    end

    // NOTE: sequential state is updated with '<=' only, so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            quo       <= '0;
            sticky    <= 1'b0;
            meta_out  <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            div_op    <= 1'b0;
            divisor   <= '0;
            rem       <= '0;
            rad       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        div_op   <= is_divide;
                        divisor  <= rhs_mant;
                        meta_out <= meta_in;
                        cnt      <= '0;
                        quo      <= '0;
                        sticky   <= 1'b0;
                        busy     <= 1'b1;
                        rem      <= is_divide ? {6'b0, lhs_mant} : '0;
                        // The radicand is scaled by 2^27 so that 26 bit pairs yield a 26-bit root.
                        rad      <= {(sqrt_odd_expo ? {lhs_mant, 1'b0} : {1'b0, lhs_mant}), 27'b0};
                        if (special) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    rad <= rad_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sticky    <= (rem_nx != '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fpu_div_sqrt_iter.md
Name: fpu_div_sqrt_iter

Overview:
- Multi-cycle mantissa recurrence engine for FDIV/FSQRT, with a valid/ready handshake on both sides.
- Upstream: the pre-processing stage, which supplies normalized mantissas, the special-case decision and packed metadata (sign, virtual exponent, NaN/Inf/zero flags, NaN payload).
- Function: computes the raw quotient or root plus a sticky bit.
- Downstream: the normalize/round stage, which consumes the result together with the unchanged metadata.

Parameters:
META_W, 64, width of the opaque metadata passed through unchanged
BITS_PER_CYCLE, 1, result bits retired per cycle; legal values 1 or 2; iteration count N = 26/BITS_PER_CYCLE

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  synchronous kill of any in-flight operation
in_valid  input  1  operands present
in_ready  output  1  block can accept operands this cycle
is_divide  input  1  1 = divide lhs/rhs, 0 = sqrt(lhs)
lhs_mant  input  24  dividend or radicand mantissa, bit23 = hidden 1
rhs_mant  input  24  divisor mantissa, bit23 = hidden 1; ignored for sqrt
sqrt_odd_expo  input  1  sqrt only: radicand is doubled (odd unbiased exponent)
special  input  1  result is decided upstream (NaN/Inf/zero); skip iterations
meta_in  input  META_W  pass-through metadata
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
quo  output  26  quotient/root, bit25 weight 2^0, 25 fraction bits
sticky  output  1  1 if the exact result is not representable in quo
meta_out  output  META_W  meta_in captured at acceptance
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=1 at an edge):
  - state goes to IDLE.
  - out_valid, quo, sticky, meta_out, busy and the internal counter all go to 0.
  - in_ready is 0 during the reset cycle.
- in_ready = (state==IDLE) && !flush && !rst.
- Accept: on an edge with in_valid && in_ready, capture is_divide, operands, sqrt_odd_expo and meta_in.
  - special=1: go directly to DONE, with quo=0 and sticky=0. out_valid is high in the cycle after acceptance.
  - special=0: go to BUSY with the counter at 0.
- BUSY: each edge retires BITS_PER_CYCLE result bits, MSB first, and increments the counter.
  - After the N-th iteration edge the state is DONE.
  - out_valid is first high N cycles after the acceptance edge (26 cycles at default).
- Divide definition, with A = lhs_mant and B = rhs_mant:
  - quo = floor(A*2^25/B).
  - sticky = (A*2^25 mod B) != 0.
  - Restoring or non-restoring recurrence is allowed.
  - Partial remainder must fit in 27 bits.
  - With A and B in [2^23, 2^24), quo lies in (2^24, 2^26).
- Sqrt definition:
  - R = sqrt_odd_expo ? {lhs_mant,1'b0} : {1'b0,lhs_mant}, a 25-bit value with 23 fraction bits, so R is in [1,4).
  - quo = floor(sqrt(R/2^23)*2^25), always in [2^25, 2^26).
  - sticky = (R*2^27 != quo^2).
  - Bit-serial restoring recurrence; partial remainder is at most 28 bits.
- DONE:
  - out_valid=1; quo, sticky and meta_out are held stable until out_ready.
  - The edge with out_valid && out_ready returns to IDLE, and out_valid drops the next cycle.
  - No new accept occurs in the handoff cycle (in_ready=0 in DONE).
- flush: at an edge it forces IDLE from any state, overriding accept, iteration and handoff.
  - out_valid is 0 the next cycle.
  - quo, sticky and meta_out contents are don't-care once out_valid=0.
- Precedence at an edge: rst > flush > normal operation.
- Operands with bit23=0 (non-normalized) are a precondition violation. Upstream normalizes them, and the result is unspecified.
- Divide by zero, NaN and Inf are never iterated; upstream asserts special for them.
- meta_out changes only at acceptance.

Test Plan:
- Divide 1.5/1.0 (lhs=0xC00000, rhs=0x800000) -> out_valid 26 cycles after accept; quo=0x3000000, sticky=0.
- Divide 1.0/1.5 (lhs=0x800000, rhs=0xC00000) -> quo=0x1555555, sticky=1; meta_out equals meta_in.
- Sqrt even, lhs=0x800000 -> quo=0x2000000, sticky=0. Sqrt odd with lhs=0x900000 (R=2.25) -> quo=0x3000000, sticky=0. Sqrt even with lhs=0x800000, sqrt_odd_expo=1 (R=2) -> quo=0x2D413CC, sticky=1.
- special=1 -> out_valid the cycle after accept, quo=0. Then hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Then pulse out_ready -> IDLE, and a back-to-back accept succeeds the following cycle.
- flush asserted at BUSY iteration 10 -> out_valid never rises, in_ready=1 the cycle after flush, and a fresh divide completes correctly. Repeat the same sequence with rst instead of flush.
- BITS_PER_CYCLE=2 with the first three vectors -> identical results, with out_valid 13 cycles after accept.
